risc_loader: RTL and testbench

Boot and run controller for the VeriRISC core. It sits directly upstream of the CPU top module:
- accepts a program image as a valid/ready byte stream;
- writes the image into the 32x8 program memory;
- holds the CPU in reset during loading, then releases it;
- counts run cycles until `halt` or a watchdog limit is reached.

It replaces the hand-poked memory and reset/clock tasks used in bring-up with a synthesizable sequencer.

---
 rtl/risc_loader_if.sv | 23 ++
 rtl/risc_loader.sv | 161 ++++++++++++++++
 tb/tb_risc_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/risc_loader_if.sv
// Image stream and program-memory write port of the VeriRISC boot loader.
// The master modport is the loader side; the slave modport is the source/memory side.
interface risc_loader_if #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/risc_loader.sv
// Boot/run sequencer for VeriRISC: streams an image into program memory, resets the core, runs it under a watchdog.
// Optional byte checksum of the image is enabled by defining LOADER_CHECKSUM_EN.
module risc_loader #(
    parameter int unsigned AWIDTH     = 5,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned CW         = 16,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH:0]   len,
    input  logic [CW-1:0]     max_cycles,
    risc_loader_if.master     bus,
    input  logic              halt,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CW-1:0]     cycles,
    output logic [DWIDTH-1:0] checksum
);
    localparam int unsigned LW  = AWIDTH + 1;
    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [LW-1:0]  DEPTH   = LW'(1) << AWIDTH;
    localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CRST, RUN, DONE} state_t;

    state_t            state, state_d;
    logic [AWIDTH-1:0] ptr, ptr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [RCW-1:0]    rcnt, rcnt_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [CW-1:0]     max_q, max_d;
    logic [CW-1:0]     cycles_d;
    logic              timeout_d;
    logic              ready_q;
    logic              accept;
    logic              beat;

    assign beat           = ready_q && bus.in_valid;
    assign bus.in_ready   = ready_q;
    assign bus.mem_wr     = beat;
    assign bus.mem_addr   = ptr;
    assign bus.mem_wdata  = bus.in_data;

    // State and datapath register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            len_q   <= '0;
            rcnt    <= '0;
            cnt     <= '0;
            max_q   <= '0;
            ready_q <= 1'b0;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            cycles  <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            len_q   <= len_d;
            rcnt    <= rcnt_d;
            cnt     <= cnt_d;
            max_q   <= max_d;
            ready_q <= (state_d == LOAD);
            cpu_rst <= (state_d != RUN);
            busy    <= (state_d == LOAD) || (state_d == CRST) || (state_d == RUN);
            done    <= (state_d == DONE);
            timeout <= timeout_d;
            cycles  <= cycles_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        len_d     = len_q;
        rcnt_d    = rcnt;
        cnt_d     = cnt;
        max_d     = max_q;
        timeout_d = timeout;
        cycles_d  = cycles;
        accept    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                    max_d     = max_cycles;
                    ptr_d     = '0;
                    rcnt_d    = '0;
                    len_d     = (len > DEPTH) ? DEPTH : len;
                    state_d   = (len == '0) ? CRST : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    ptr_d = ptr + AWIDTH'(1);
                    if (LW'(ptr) + LW'(1) == len_q) begin
                        state_d = CRST;
                        rcnt_d  = '0;
                    end
                end
            end
            CRST: begin
                if (rcnt == RC_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    rcnt_d = rcnt + RCW'(1);
                end
            end
            RUN: begin
                // halt has priority over a coincident watchdog expiry
                if (halt) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                    cycles_d  = cnt;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if ((max_q != '0) && (cnt_d == max_q)) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        cycles_d  = max_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DWIDTH-1:0] sum_q;

    // Running modulo-2^DWIDTH sum of accepted image bytes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (beat) begin
            sum_q <= sum_q + bus.in_data;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign checksum      = '0;
`endif

endmodule

// File: tb/tb_risc_loader.sv
// Scoreboard bench for risc_loader: random jobs, expected writes/results queued at issue, checked by a monitor.
module tb_risc_loader;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned RSTC  = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic [AW:0]   len = '0;
    logic [CW-1:0] max_cycles = '0;
    logic          cpu_rst, busy, done, timeout;
    logic [CW-1:0] cycles;
    logic [DW-1:0] checksum;

    risc_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    risc_loader #(.AWIDTH(AW), .DWIDTH(DW), .CW(CW), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .max_cycles(max_cycles),
        .bus(bus), .halt(halt), .cpu_rst(cpu_rst), .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [CW-1:0] cyc; logic to; logic [DW-1:0] sum; } res_t;

    wr_t           exp_wr[$];
    res_t          exp_res[$];
    logic [DW-1:0] img[$];
    int            checks = 0;
    int            errors = 0;
    int            halt_at = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Stub CPU: raises halt on RUN clock number halt_at (0 = never)
    int run_clk = 0;
    always @(posedge clk) begin
        #1;
        if (cpu_rst) begin
            run_clk = 0;
            halt    = 1'b0;
        end else begin
            run_clk++;
            halt = (halt_at != 0) && (run_clk == halt_at);
        end
    end

    int   cyc = 0;
    int   last_beat_cyc = 0;
    bit   loaded = 1'b0;
    logic cpu_rst_prev = 1'b1;
    logic done_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected writes and results as the DUT presents them
    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (rst === 1'b1) begin
            if (bus.mem_wr) begin
                if (exp_wr.size() == 0) begin
                    chk("mem_wr_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr.pop_front();
                    chk("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
                    chk("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
                end
                last_beat_cyc = cyc;
                loaded = 1'b1;
            end
            if (cpu_rst_prev && !cpu_rst && loaded) begin
                chk("crst_latency", 32'(cyc - last_beat_cyc), 32'(RSTC + 1));
                loaded = 1'b0;
            end
            if (done && !done_prev) begin
                if (exp_res.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'(0));
                end else begin
                    r = exp_res.pop_front();
                    chk("cycles", 32'(cycles), 32'(r.cyc));
                    chk("timeout", 32'(timeout), 32'(r.to));
                    chk("checksum", 32'(checksum), 32'(r.sum));
                    chk("cpu_rst_done", 32'(cpu_rst), 32'(1));
                    chk("busy_done", 32'(busy), 32'(0));
                end
            end
        end
        cpu_rst_prev = cpu_rst;
        done_prev    = done;
    end

    task automatic check_reset_values();
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'(0));
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
        chk("rst_cpu_rst", 32'(cpu_rst), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_cycles", 32'(cycles), 32'(0));
        chk("rst_checksum", 32'(checksum), 32'(0));
    endtask

    // One load-and-run job; expectations come from the loader's rules, not from the DUT
    task automatic job(input int l, input int mx, input int h);
        int   n, idx, waitc;
        bit   v;
        res_t r;
        n = (l > int'(DEPTH)) ? int'(DEPTH) : l;
        while (img.size() < n) img.push_back(DW'($urandom));
        r.sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back('{AW'(i), img[i]});
`ifdef LOADER_CHECKSUM_EN
            r.sum = r.sum + img[i];
`endif
        end
        r.to  = (mx != 0) && ((h == 0) || (h > mx));
        r.cyc = r.to ? CW'(mx) : CW'(h - 1);
        exp_res.push_back(r);
        halt_at = h;

        @(posedge clk); #1;
        start = 1'b1; len = (AW+1)'(l); max_cycles = CW'(mx);
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; waitc = 0;
        while (idx < n) begin
            if (bus.in_ready) begin
                v = ($urandom % 4) != 0;
                bus.in_valid = v;
                bus.in_data  = img[idx];
                if (v) idx++;
                waitc = 0;
            end else begin
                bus.in_valid = 1'b0;
                waitc++;
                if (waitc > 5) begin
                    chk("in_ready_stuck_low", 32'(idx), 32'(n));
                    exp_wr.delete();
                    break;
                end
            end
            @(posedge clk); #1;
        end
        // Keep offering bytes past the image end; none may be written
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;

        waitc = 0;
        while (!done && waitc < 3000) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!done) begin
            chk("done_wait_expired", 32'(done), 32'(1));
            exp_res.delete();
        end
        @(posedge clk); #1;
        img.delete();
    endtask

    initial begin
        int l, mx, h;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset in the middle of a 5-word load after 3 beats
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 3; i++) exp_wr.push_back('{AW'(i), img[i]});
        @(posedge clk); #1;
        start = 1'b1; len = (AW+1)'(5); max_cycles = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = img[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_values();
        chk("wr_pending_after_rst", 32'(exp_wr.size()), 32'(0));
        img.delete();
        @(posedge clk); #1 rst = 1'b1;

        img = '{8'h5A, 8'hC3};
        job(2, 0, 3);
        img = '{8'hA2, 8'h00, 8'h00};
        job(3, 0, 4);
        job(4, 10, 0);
        job(2, 0, 300);
        job(40, 0, 5);
        img = '{8'hFF, 8'h01, 8'h10};
        job(3, 0, 2);
        job(1, 5, 5);
        job(0, 1, 0);
        job(32, 7, 8);

        for (int k = 0; k < 10; k++) begin
            l  = int'($urandom_range(0, 40));
            mx = int'($urandom_range(0, 40));
            h  = (mx == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(0, 60));
            job(l, mx, h);
        end

        chk("wr_queue_drained", 32'(exp_wr.size()), 32'(0));
        chk("res_queue_drained", 32'(exp_res.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_time_limit checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end
endmodule
